adj_fifo_ctrl: RTL and testbench

Single-clock pointer/flag controller that sequences one adj_fifo storage instance.
- Write side: valid/ready push handshake. Drives the storage's wr_en and addr_in.
- Read side: valid/ready pop handshake. Drives addr_out; storage dout is read combinationally at addr_out.
- Tracks occupancy, full/empty/almost_full, sticky overflow/underflow errors, and a synchronous flush.
- Sits between an RTIO event producer/consumer pair and the adj_fifo storage.

---
 rtl/adj_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_adj_fifo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adj_fifo_ctrl.sv
// Pointer/flag controller for one adj_fifo storage instance: valid/ready push and
// pop handshakes, occupancy tracking, sticky error flags and a synchronous flush.
module adj_fifo_ctrl #(
  parameter int DEPTH     = 1024,
  parameter int THRESHOLD = 1000,
  parameter int ADDR_LEN  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  output logic                pop_valid,
  input  logic                pop_ready,
  input  logic                flush,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] addr_in,
  output logic [ADDR_LEN-1:0] addr_out,
  output logic [ADDR_LEN:0]   count,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic                underflow
);

  localparam int CNT_W = ADDR_LEN + 1;
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH - 1);
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    THR_CNT   = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL, S_FLUSH} state_t;

  state_t              state, state_nx;
  logic [ADDR_LEN-1:0] addr_in_nx, addr_out_nx;
  logic [CNT_W-1:0]    count_nx;
  logic                overflow_nx, underflow_nx;
  logic                do_push, do_pop;

  assign do_push = push_valid & push_ready;
  assign do_pop  = pop_valid & pop_ready;
  assign wr_en   = do_push & ~flush;

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    addr_in_nx   = addr_in;
    addr_out_nx  = addr_out;
    count_nx     = count;
    overflow_nx  = overflow;
    underflow_nx = underflow;
    if (flush) begin
      state_nx     = S_FLUSH;
      addr_in_nx   = '0;
      addr_out_nx  = '0;
      count_nx     = '0;
      overflow_nx  = 1'b0;
      underflow_nx = 1'b0;
    end else begin
      if (state == S_FULL && push_valid && !push_ready) overflow_nx = 1'b1;
      if (state == S_EMPTY && pop_ready && !pop_valid)  underflow_nx = 1'b1;
      // Pointers wrap at DEPTH, which need not be a power of two.
      if (do_push) addr_in_nx  = (addr_in == LAST_ADDR)  ? '0 : addr_in + 1'b1;
      if (do_pop)  addr_out_nx = (addr_out == LAST_ADDR) ? '0 : addr_out + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_nx = count + 1'b1;
        2'b01:   count_nx = count - 1'b1;
        default: count_nx = count;
      endcase
      if (count_nx == '0)            state_nx = S_EMPTY;
      else if (count_nx == DEPTH_CNT) state_nx = S_FULL;
      else                            state_nx = S_PARTIAL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_EMPTY;
      addr_in     <= '0;
      addr_out    <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      push_ready  <= 1'b0;
      pop_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      addr_in     <= addr_in_nx;
      addr_out    <= addr_out_nx;
      count       <= count_nx;
      empty       <= (count_nx == '0);
      full        <= (count_nx == DEPTH_CNT);
      almost_full <= (count_nx >= THR_CNT);
      overflow    <= overflow_nx;
      underflow   <= underflow_nx;
      // Handshake enables follow the state being entered, not the one being left.
      push_ready  <= (state_nx == S_EMPTY) || (state_nx == S_PARTIAL);
      pop_valid   <= (state_nx == S_PARTIAL) || (state_nx == S_FULL);
    end
  end

endmodule

// File: tb/tb_adj_fifo_ctrl.sv
// Self-checking bench for adj_fifo_ctrl: queue-based reference model, per-cycle
// comparison on the falling edge, directed scenarios plus randomized traffic.
module tb_adj_fifo_ctrl;
  localparam int DEPTH = 5;
  localparam int THRESHOLD = 4;
  localparam int ADDR_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push_valid = 1'b0, pop_ready = 1'b0, flush = 1'b0;
  logic push_ready, pop_valid, wr_en, empty, full, almost_full, overflow, underflow;
  logic [ADDR_LEN-1:0] addr_in, addr_out;
  logic [ADDR_LEN:0]   count;
  logic [7:0] din = 8'h00;
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] dout;

  int n_checks = 0;
  int n_err = 0;

  adj_fifo_ctrl #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .ADDR_LEN(ADDR_LEN)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .flush(flush), .wr_en(wr_en),
    .addr_in(addr_in), .addr_out(addr_out), .count(count), .empty(empty),
    .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Storage stand-in: written on wr_en, read combinationally at addr_out.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  always @(posedge clk) if (wr_en) mem[addr_in] <= din;
  assign dout = (addr_out < DEPTH) ? mem[addr_out] : 8'hxx;

  // Reference model: contents queue, modular pointers, and two gating bits
  // (m_gate: handshakes blocked after reset/flush; m_fst: flush state).
  logic [7:0] q[$];
  int m_wp, m_rp;
  bit m_gate, m_fst, m_ovf, m_unf;

  function automatic bit exp_pr();
    return !m_gate && (q.size() < DEPTH);
  endfunction
  function automatic bit exp_pv();
    return !m_gate && (q.size() > 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete(); m_wp = 0; m_rp = 0; m_gate = 1; m_fst = 0; m_ovf = 0; m_unf = 0;
    end else begin
      bit pr, pv;
      pr = exp_pr();
      pv = exp_pv();
      if (flush) begin
        q.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_gate = 1; m_fst = 1;
      end else begin
        if (!m_fst && q.size() == DEPTH && push_valid) m_ovf = 1;
        if (!m_fst && q.size() == 0 && pop_ready) m_unf = 1;
        if (pv && pop_ready) begin
          void'(q.pop_front());
          m_rp = (m_rp + 1) % DEPTH;
        end
        if (pr && push_valid) begin
          q.push_back(din);
          m_wp = (m_wp + 1) % DEPTH;
        end
        m_gate = 0; m_fst = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("push_ready", push_ready, exp_pr());
      check("pop_valid", pop_valid, exp_pv());
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      check("almost_full", almost_full, q.size() >= THRESHOLD);
      check("overflow", overflow, m_ovf);
      check("underflow", underflow, m_unf);
      check("addr_in", addr_in, m_wp);
      check("addr_out", addr_out, m_rp);
      check("wr_en", wr_en, push_valid && exp_pr() && !flush);
      if (exp_pv() && pop_ready && !flush) check("dout", dout, q[0]);
    end
  end

  task automatic cyc(input bit pv, input bit pr, input bit fl);
    push_valid = pv; pop_ready = pr; flush = fl;
    din = 8'($urandom);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with push_valid asserted.
    push_valid = 1'b1;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_push_ready", push_ready, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_addr_in", addr_in, 0);
    check("rst_addr_out", addr_out, 0);
    check("rst_wr_en", wr_en, 0);
    rst = 1'b1; push_valid = 1'b0;
    @(posedge clk); #1;
    check("startup_push_ready", push_ready, 1);

    // Fill and wrap.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check("fill4_almost_full", almost_full, 1);
    check("fill4_full", full, 0);
    cyc(1, 0, 0);
    check("fill5_count", count, 5);
    check("fill5_full", full, 1);
    check("fill5_push_ready", push_ready, 0);
    check("fill5_addr_in", addr_in, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    check("drain_addr_out", addr_out, 0);
    check("drain_empty", empty, 1);

    // Simultaneous push/pop at count 2.
    cyc(1, 0, 0); cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    check("pp_count", count, 2);
    check("pp_addr_in", addr_in, 2);
    check("pp_addr_out", addr_out, 0);
    cyc(0, 1, 0); cyc(0, 1, 0);

    // Overflow.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    push_valid = 1'b1; #1;
    check("ovf_wr_en", wr_en, 0);
    cyc(1, 0, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 5);
    cyc(0, 1, 0);
    check("ovf_pop_push_ready", push_ready, 1);
    check("ovf_sticky", overflow, 1);

    // Underflow.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("unf_flag", underflow, 1);
    check("unf_count", count, 0);
    check("unf_addr_out", addr_out, 2);

    // Flush mid-operation with both handshakes requested.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    push_valid = 1'b1; pop_ready = 1'b1; flush = 1'b1; #1;
    check("flush_wr_en", wr_en, 0);
    cyc(1, 1, 1);
    check("flush_count", count, 0);
    check("flush_addr_in", addr_in, 0);
    check("flush_addr_out", addr_out, 0);
    check("flush_ovf", overflow, 0);
    check("flush_unf", underflow, 0);
    check("flush_push_ready", push_ready, 0);
    check("flush_pop_valid", pop_valid, 0);
    cyc(0, 0, 0);
    check("after_flush_push_ready", push_ready, 1);

    // Randomized traffic with varying bias and occasional flush.
    for (int seg = 0; seg < 40; seg++) begin
      int p_push, p_pop;
      p_push = $urandom_range(90, 10);
      p_pop  = $urandom_range(90, 10);
      for (int i = 0; i < 50; i++)
        cyc($urandom_range(99) < p_push, $urandom_range(99) < p_pop, $urandom_range(39) == 0);
    end

    // Asynchronous reset mid-operation.
    cyc(1, 0, 0); cyc(1, 0, 0);
    push_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_addr_in", addr_in, 0);
    check("async_rst_push_ready", push_ready, 0);
    check("async_rst_empty", empty, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("async_rst_startup", push_ready, 1);
    for (int i = 0; i < 20; i++) cyc($urandom_range(1), $urandom_range(1), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
